cacheline_burst_adaptor: RTL
============================

# cacheline_burst_adaptor

Bridges the cache's full-line memory port to the burst-oriented physical memory. A 256-bit line read or write from the cache controller is converted into four 64-bit beats on the memory side. The block sits between the cache datapath/controller, which owns the line storage, and physical memory. It gives the cache a single-response line interface regardless of memory beat spacing.

## Interface
- LINE_WIDTH, 256, cache line width in bits
- BURST_WIDTH, 64, memory beat width in bits; LINE_WIDTH/BURST_WIDTH (BEATS) must be a power of two ≥ 2
- ADDR_WIDTH, 32, byte address width
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous reset, active-low (reset when 0)
- line_i  input  LINE_WIDTH  line to write, sampled with write_i in IDLE
- address_i  input  ADDR_WIDTH  line byte address, sampled with request
- read_i  input  1  cache line-read request, held until resp_o
- write_i  input  1  cache line-write request, held until resp_o
- line_o  output  LINE_WIDTH  assembled read line, valid while resp_o=1 after a read
- resp_o  output  1  one-cycle completion pulse
- burst_i  input  BURST_WIDTH  memory read beat
- burst_o  output  BURST_WIDTH  memory write beat
- address_o  output  ADDR_WIDTH  registered line address, low log2(LINE_WIDTH/8) bits forced 0
- read_o  output  1  memory read command, held for whole burst
- write_o  output  1  memory write command, held for whole burst
- resp_i  input  1  memory beat handshake: one beat transferred per cycle it is 1

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: if write_i, capture line_i into write buffer and address_i into address_o, clear beat count, go to WRITE. Else if read_i, capture address and go to READ. write_i has priority when both are asserted.
- READ: read_o=1. On each resp_i=1, store burst_i into read buffer beat[count] and increment count. The beat with count=BEATS-1 sends the FSM to DONE.
- WRITE: write_o=1. burst_o = write buffer beat[count]. On each resp_i=1, increment count. The last beat sends the FSM to DONE.
- Beat order is little-endian: beat k = line bits [BURST_WIDTH*k +: BURST_WIDTH].
- DONE: resp_o=1 for exactly one cycle, line_o = read buffer, then unconditionally return to IDLE.
- resp_i is ignored in IDLE and DONE.
- Gaps are allowed: resp_i may be low between beats, and the count holds during a gap.
- burst_o = 0 outside WRITE. line_o holds the last assembled line until the next read completes.
- The counter is log2(BEATS) bits, wraps to 0 on the last beat, and is never read after the wrap.
- Reset (rst=0) at any time:
  - state goes to IDLE, count to 0;
  - read_o, write_o, resp_o, address_o, burst_o, line_o and both buffers go to 0;
  - an in-flight burst is abandoned with no resp_o.

## Timing
- All outputs are driven from registers or from the state/count plus buffer registers. No combinational path exists from cache inputs to memory outputs.
- Request sampled in IDLE at edge N → read_o/write_o high from cycle N+1.
- Fourth resp_i at edge M → read_o/write_o low and resp_o high in cycle M+1 → IDLE in cycle M+2.
- Minimum turnaround with back-to-back resp_i is 1 (IDLE) + 4 + 1 (DONE) = 6 cycles per line.
- The cache drops its request in the cycle after seeing resp_o. The IDLE cycle after DONE re-samples requests, so a held request starts a new transaction.

## Structure
- Shared package: state enum (IDLE, READ, WRITE, DONE), default LINE_WIDTH/BURST_WIDTH/ADDR_WIDTH constants, derived BEATS and count width.
- Single module; no sub-module. Read and write buffers are plain registers indexed by the count.

## Test plan
- Read, resp_i on 4 consecutive cycles:
  - stimulus: address_i=0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44;
  - response: address_o=0x0000_1220, read_o high exactly 4 cycles, resp_o pulses once with line_o = {0x44..,0x33..,0x22..,0x11..}.
- Write of line_i = 256'h(0x0F..F0 pattern per beat), resp_i with 2-cycle gaps between beats → burst_o matches beat[k] at each resp_i, burst_o held during gaps, one resp_o pulse.
- read_i and write_i asserted together in IDLE → write burst executes, read_o never asserted.
- Reset asserted after 2 read beats → next cycle read_o=0, resp_o=0, line_o=0. A subsequent full read completes correctly.
- resp_i toggled in IDLE and DONE → no state change, no extra beat counted.
- Two back-to-back reads with request held through DONE:
  - second burst starts 1 cycle after DONE;
  - first line_o remains stable until the second resp_o.

Source files
------------

// File: rtl/cacheline_burst_adaptor_pkg.sv
// ---------------------------------------------------------------------------
// cacheline_burst_adaptor_pkg
// Shared definitions for the cache-line to memory-burst adaptor: the FSM state
// encoding and the default geometry (line, beat and address widths) together
// with the beat count and beat counter width derived from them.
// ---------------------------------------------------------------------------
package cacheline_burst_adaptor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_LINE_WIDTH  = 256;
    localparam int DEF_BURST_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH  = 32;

    // Beats per line; must be a power of two >= 2 so the counter wraps exactly.
    localparam int DEF_BEATS = DEF_LINE_WIDTH / DEF_BURST_WIDTH;
    localparam int DEF_CNT_W = $clog2(DEF_BEATS);

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// ---------------------------------------------------------------------------
// cacheline_burst_adaptor
// Converts one full-line read or write from the cache controller into a burst
// of BEATS memory beats (little-endian beat order) and answers the cache with
// a single one-cycle resp_o pulse per line.
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst        : synchronous reset, active low
//   line_i     : line to write, captured with write_i in IDLE
//   address_i  : line byte address, captured with the request in IDLE
//   read_i     : cache line-read request, held until resp_o
//   write_i    : cache line-write request, held until resp_o (wins over read_i)
//   line_o     : last assembled read line, valid while resp_o after a read
//   resp_o     : one-cycle completion pulse
//   burst_i    : memory read beat
//   burst_o    : memory write beat (0 outside WRITE)
//   address_o  : registered line address, line-offset bits forced to 0
//   read_o     : memory read command, high for the whole burst
//   write_o    : memory write command, high for the whole burst
//   resp_i     : memory beat handshake, one beat per cycle it is high
// ---------------------------------------------------------------------------
module cacheline_burst_adaptor
    import cacheline_burst_adaptor_pkg::*;
#(
    parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
    parameter int BURST_WIDTH = DEF_BURST_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LINE_WIDTH-1:0]  line_i,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    localparam int BEATS  = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int OFFS_W = $clog2(LINE_WIDTH / 8);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFFS_W;
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_count;
    logic [LINE_WIDTH-1:0]  r_wbuf;
    logic [LINE_WIDTH-1:0]  r_rbuf;
    logic [LINE_WIDTH-1:0]  r_line;
    logic [ADDR_WIDTH-1:0]  r_addr;

    logic [LINE_WIDTH-1:0]  w_rbuf_merged;
    logic [BURST_WIDTH-1:0] w_wbeat [BEATS];
    logic                   w_last_beat;

    // Beat views of the buffers: w_wbeat slices the write buffer for the
    // burst_o mux, w_rbuf_merged is the read buffer with the incoming beat
    // dropped into the slot selected by the counter.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
            assign w_wbeat[gi] = r_wbuf[gi*BURST_WIDTH +: BURST_WIDTH];
            assign w_rbuf_merged[gi*BURST_WIDTH +: BURST_WIDTH] =
                (r_count == CNT_W'(gi)) ? burst_i
                                        : r_rbuf[gi*BURST_WIDTH +: BURST_WIDTH];
        end
    endgenerate

    assign w_last_beat = resp_i && (r_count == LAST_BEAT);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (write_i) begin
                    w_state_next = WRITE;
                end else if (read_i) begin
                    w_state_next = READ;
                end
            end
            READ, WRITE: begin
                if (w_last_beat) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_wbuf  <= '0;
            r_rbuf  <= '0;
            r_line  <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (write_i) begin
                        r_wbuf  <= line_i;
                        r_addr  <= address_i & LINE_MASK;
                        r_count <= '0;
                    end else if (read_i) begin
                        r_addr  <= address_i & LINE_MASK;
                        r_count <= '0;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        r_rbuf  <= w_rbuf_merged;
                        r_count <= r_count + 1'b1;
                        // line_o is a separate copy so it stays stable while
                        // the next read refills the read buffer.
                        if (r_count == LAST_BEAT) begin
                            r_line <= w_rbuf_merged;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign read_o    = (r_state == READ);
    assign write_o   = (r_state == WRITE);
    assign resp_o    = (r_state == DONE);
    assign burst_o   = (r_state == WRITE) ? w_wbeat[r_count] : '0;
    assign line_o    = r_line;
    assign address_o = r_addr;

endmodule
